// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit.
// FSM state encoding, branch/jump field constants and the next-PC select code.
// Optional build macro affecting users of this package: PC_ALIGN_CHECK_EN.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } pc_state_e;

  localparam int BRANCH_SHIFT = 2;
  localparam int JUMP_IDX_W   = 26;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_SEQ    = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_JREG   = 3'd4,
    SEL_EPC    = 3'd5,
    SEL_VECTOR = 3'd6
  } next_sel_e;

  // BEQ takes the branch on zero, BNE on non-zero.
  function automatic logic branch_taken(input logic branch,
                                        input logic zero,
                                        input logic branch_ne);
    return branch & (zero ^ branch_ne);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control inputs and address outputs of the program-counter unit.
// The slave modport is the PC unit itself; the master modport is the core side.
// With PC_ALIGN_CHECK_EN defined, a misaligned pulse is carried as well.
interface pc_unit_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);

  logic [31:0]       instruction;
  logic              zero;
  logic              branch;
  logic              branch_ne;
  logic              jump;
  logic              jump_reg;
  logic [ADDR_W-1:0] rs_data;
  logic              stall;
  logic              exception;
  logic              eret;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] epc;
  logic              in_trap;
  logic [CNT_W-1:0]  retired;
`ifdef PC_ALIGN_CHECK_EN
  logic              misaligned;
`endif

  modport master (
    output instruction, zero, branch, branch_ne, jump, jump_reg, rs_data,
    output stall, exception, eret,
`ifdef PC_ALIGN_CHECK_EN
    input  misaligned,
`endif
    input  addr, pc_plus4, epc, in_trap, retired
  );

  modport slave (
    input  instruction, zero, branch, branch_ne, jump, jump_reg, rs_data,
    input  stall, exception, eret,
`ifdef PC_ALIGN_CHECK_EN
    output misaligned,
`endif
    output addr, pc_plus4, epc, in_trap, retired
  );

endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: purely combinational candidate-address generator.
// Produces addr+4, the PC-relative branch target, the region-relative J/JAL
// target and the word-aligned JR target; pc_unit picks among them.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       instruction,
  input  logic [ADDR_W-1:0] rs_data,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] jreg_target
);

  logic [ADDR_W-1:0]       imm_sext;
  logic [ADDR_W-1:0]       branch_offset;
  logic [JUMP_IDX_W+1:0]   jump_low;
  logic                    unused_bits;

  assign pc_plus4      = addr + ADDR_W'(4);
  assign imm_sext      = {{(ADDR_W-16){instruction[15]}}, instruction[15:0]};
  assign branch_offset = imm_sext << BRANCH_SHIFT;
  assign branch_target = pc_plus4 + branch_offset;
  assign jump_low      = {instruction[JUMP_IDX_W-1:0], 2'b00};

  // The jump index covers the low 28 bits; any bits above come from pc_plus4.
  generate
    if (ADDR_W > JUMP_IDX_W + 2) begin : g_region
      assign jump_target = {pc_plus4[ADDR_W-1:JUMP_IDX_W+2], jump_low};
    end else begin : g_no_region
      assign jump_target = jump_low;
    end
  endgenerate

  assign jreg_target = {rs_data[ADDR_W-1:2], 2'b00};

  // Opcode bits and the JR low bits play no part in target generation.
  assign unused_bits = ^{instruction[31:JUMP_IDX_W], rs_data[1:0]};

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the single-cycle MIPS core.
// BOOT/RUN/TRAP FSM, next-PC selection, EPC register and retired counter.
// Optional feature macro: PC_ALIGN_CHECK_EN (JR to a non-word address traps
// and pulses bus.misaligned instead of silently clearing the low bits).
module pc_unit
  import pc_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter int          CNT_W      = 32
) (
  input  logic       clk,
  input  logic       reset,
  pc_unit_if.slave   bus
);

  localparam logic [ADDR_W-1:0] RESET_PC = RESET_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] EXC_PC   = EXC_VECTOR[ADDR_W-1:0];

  pc_state_e         state, state_next;
  next_sel_e         sel;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [ADDR_W-1:0] epc_q;
  logic [CNT_W-1:0]  retired_q;
  logic              take_trap;
  logic              retire;
  logic [ADDR_W-1:0] pc_plus4, branch_target, jump_target, jreg_target;
`ifdef PC_ALIGN_CHECK_EN
  logic              misaligned_now;
`endif

  pc_next_calc #(.ADDR_W(ADDR_W)) u_next_calc (
    .addr          (addr_q),
    .instruction   (bus.instruction),
    .rs_data       (bus.rs_data),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jreg_target   (jreg_target)
  );

  // Next-state and next-PC source selection, RUN inputs in priority order.
  always_comb begin
    state_next = state;
    sel        = SEL_HOLD;
    take_trap  = 1'b0;
    retire     = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misaligned_now = 1'b0;
`endif
    case (state)
      ST_BOOT: begin
        state_next = ST_RUN;
        sel        = SEL_HOLD;
      end
      ST_TRAP: begin
        state_next = ST_RUN;
        sel        = bus.stall ? SEL_HOLD : SEL_SEQ;
      end
      ST_RUN: begin
        if (bus.exception) begin
          take_trap = 1'b1;
        end else if (bus.eret) begin
          sel = SEL_EPC;
        end else if (bus.stall) begin
          sel = SEL_HOLD;
        end else if (bus.jump_reg) begin
`ifdef PC_ALIGN_CHECK_EN
          if (bus.rs_data[1:0] != 2'b00) begin
            take_trap      = 1'b1;
            misaligned_now = 1'b1;
          end else begin
            sel = SEL_JREG;
          end
`else
          sel = SEL_JREG;
`endif
        end else if (bus.jump) begin
          sel = SEL_JUMP;
        end else if (branch_taken(bus.branch, bus.zero, bus.branch_ne)) begin
          sel = SEL_BRANCH;
        end else begin
          sel = SEL_SEQ;
        end
        if (take_trap) begin
          sel        = SEL_VECTOR;
          state_next = ST_TRAP;
        end
        retire = !take_trap && (bus.eret || !bus.stall);
      end
      default: begin
        state_next = ST_BOOT;
        sel        = SEL_HOLD;
      end
    endcase
  end

  // Turn the select code into the address loaded on the next edge.
  always_comb begin
    addr_next = addr_q;
    case (sel)
      SEL_HOLD:   addr_next = addr_q;
      SEL_SEQ:    addr_next = pc_plus4;
      SEL_BRANCH: addr_next = branch_target;
      SEL_JUMP:   addr_next = jump_target;
      SEL_JREG:   addr_next = jreg_target;
      SEL_EPC:    addr_next = epc_q;
      SEL_VECTOR: addr_next = EXC_PC;
      default:    addr_next = addr_q;
    endcase
  end

  // State, PC, EPC and retired counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_BOOT;
      addr_q    <= RESET_PC;
      epc_q     <= '0;
      retired_q <= '0;
    end else begin
      state  <= state_next;
      addr_q <= addr_next;
      if (take_trap) begin
        epc_q <= addr_q;
      end
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign bus.addr     = addr_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.epc      = epc_q;
  assign bus.in_trap  = (state == ST_TRAP);
  assign bus.retired  = retired_q;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.misaligned = misaligned_now;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (32-bit build).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
// With PC_ALIGN_CHECK_EN defined, the misaligned-JR trap is checked instead
// of the silent low-bit clearing.
module tb_pc_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  pc_unit_if #(.ADDR_W(32), .CNT_W(32)) bus ();

  pc_unit #(
    .ADDR_W     (32),
    .RESET_ADDR (32'h0000_0000),
    .EXC_VECTOR (32'h8000_0180),
    .CNT_W      (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.instruction = 32'h0;
    bus.zero        = 1'b0;
    bus.branch      = 1'b0;
    bus.branch_ne   = 1'b0;
    bus.jump        = 1'b0;
    bus.jump_reg    = 1'b0;
    bus.rs_data     = 32'h0;
    bus.stall       = 1'b0;
    bus.exception   = 1'b0;
    bus.eret        = 1'b0;
  endtask

  // Leaves the DUT in RUN at addr 0 with retired 0 and epc 0.
  task automatic reset_to_run();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    checks++; if (bus.addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr: got %h want %h", bus.addr, 32'h0); end
    checks++; if (bus.epc !== 32'h0) begin failures++; $display("[TB] FAIL reset_epc: got %h want %h", bus.epc, 32'h0); end
    checks++; if (bus.retired !== 32'd0) begin failures++; $display("[TB] FAIL reset_retired: got %0d want 0", bus.retired); end
    checks++; if (bus.in_trap !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_trap: got %b want 0", bus.in_trap); end
    reset = 1'b0;
    tick();
    checks++; if (bus.addr !== 32'h0) begin failures++; $display("[TB] FAIL boot_hold_addr: got %h want %h", bus.addr, 32'h0); end
    checks++; if (bus.retired !== 32'd0) begin failures++; $display("[TB] FAIL boot_retired: got %0d want 0", bus.retired); end
    tick();
    tick();
    checks++; if (bus.addr !== 32'h8) begin failures++; $display("[TB] FAIL run2_addr: got %h want %h", bus.addr, 32'h8); end
    checks++; if (bus.retired !== 32'd2) begin failures++; $display("[TB] FAIL run2_retired: got %0d want 2", bus.retired); end
  endtask

  // Continues from addr 0x8, retired 2.
  task automatic test_branch_jump();
    clear_inputs();
    bus.branch = 1'b1; bus.zero = 1'b1; bus.instruction = 32'h0000_1000;
    tick();
    checks++; if (bus.addr !== 32'h0000_400C) begin failures++; $display("[TB] FAIL beq_fwd: got %h want %h", bus.addr, 32'h400C); end
    checks++; if (bus.retired !== 32'd3) begin failures++; $display("[TB] FAIL beq_retired: got %0d want 3", bus.retired); end
    bus.instruction = 32'h0000_FF98;
    tick();
    checks++; if (bus.addr !== 32'h0000_3E70) begin failures++; $display("[TB] FAIL beq_back: got %h want %h", bus.addr, 32'h3E70); end
    checks++; if (bus.pc_plus4 !== 32'h0000_3E74) begin failures++; $display("[TB] FAIL pc_plus4: got %h want %h", bus.pc_plus4, 32'h3E74); end
    clear_inputs();
    bus.jump = 1'b1; bus.instruction = 32'h0008_0000;
    tick();
    checks++; if (bus.addr !== 32'h0020_0000) begin failures++; $display("[TB] FAIL jump: got %h want %h", bus.addr, 32'h0020_0000); end
    clear_inputs();
    bus.jump_reg = 1'b1; bus.rs_data = 32'h0000_1234;
    tick();
    checks++; if (bus.addr !== 32'h0000_1234) begin failures++; $display("[TB] FAIL jr: got %h want %h", bus.addr, 32'h1234); end
    bus.rs_data = 32'hA000_0000;
    tick();
    clear_inputs();
    bus.jump = 1'b1; bus.instruction = 32'h0000_0010;
    tick();
    checks++; if (bus.addr !== 32'hA000_0040) begin failures++; $display("[TB] FAIL jump_region: got %h want %h", bus.addr, 32'hA000_0040); end
    checks++; if (bus.retired !== 32'd8) begin failures++; $display("[TB] FAIL jump_retired: got %0d want 8", bus.retired); end
  endtask

  task automatic test_bne();
    clear_inputs();
    bus.jump_reg = 1'b1; bus.rs_data = 32'h10;
    tick();
    clear_inputs();
    bus.branch = 1'b1; bus.branch_ne = 1'b1; bus.zero = 1'b1; bus.instruction = 32'h0000_0003;
    tick();
    checks++; if (bus.addr !== 32'h14) begin failures++; $display("[TB] FAIL bne_not_taken: got %h want %h", bus.addr, 32'h14); end
    bus.zero = 1'b0;
    tick();
    checks++; if (bus.addr !== 32'h24) begin failures++; $display("[TB] FAIL bne_taken: got %h want %h", bus.addr, 32'h24); end
    bus.branch_ne = 1'b0;
    tick();
    checks++; if (bus.addr !== 32'h28) begin failures++; $display("[TB] FAIL beq_not_taken: got %h want %h", bus.addr, 32'h28); end
  endtask

  task automatic test_wrap();
    clear_inputs();
    bus.jump_reg = 1'b1; bus.rs_data = 32'hFFFF_FFFC;
    tick();
    checks++; if (bus.pc_plus4 !== 32'h0) begin failures++; $display("[TB] FAIL wrap_plus4: got %h want %h", bus.pc_plus4, 32'h0); end
    clear_inputs();
    tick();
    checks++; if (bus.addr !== 32'h0) begin failures++; $display("[TB] FAIL wrap_addr: got %h want %h", bus.addr, 32'h0); end
  endtask

  task automatic test_boot_ignore();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.exception = 1'b1; bus.jump = 1'b1; bus.eret = 1'b1; bus.instruction = 32'h0008_0000;
    tick();
    checks++; if (bus.addr !== 32'h0) begin failures++; $display("[TB] FAIL boot_ignore_addr: got %h want %h", bus.addr, 32'h0); end
    checks++; if (bus.in_trap !== 1'b0) begin failures++; $display("[TB] FAIL boot_ignore_trap: got %b want 0", bus.in_trap); end
    checks++; if (bus.retired !== 32'd0) begin failures++; $display("[TB] FAIL boot_ignore_retired: got %0d want 0", bus.retired); end
    clear_inputs();
  endtask

  task automatic test_stall();
    reset_to_run();
    bus.jump_reg = 1'b1; bus.rs_data = 32'h20;
    tick();
    clear_inputs();
    bus.stall = 1'b1; bus.jump = 1'b1; bus.instruction = 32'h0008_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.addr !== 32'h20) begin failures++; $display("[TB] FAIL stall_addr[%0d]: got %h want %h", i, bus.addr, 32'h20); end
      checks++; if (bus.retired !== 32'd1) begin failures++; $display("[TB] FAIL stall_retired[%0d]: got %0d want 1", i, bus.retired); end
    end
    clear_inputs();
    tick();
    checks++; if (bus.addr !== 32'h24) begin failures++; $display("[TB] FAIL unstall_addr: got %h want %h", bus.addr, 32'h24); end
    checks++; if (bus.retired !== 32'd2) begin failures++; $display("[TB] FAIL unstall_retired: got %0d want 2", bus.retired); end
  endtask

  task automatic test_exception();
    reset_to_run();
    bus.jump_reg = 1'b1; bus.rs_data = 32'h40;
    tick();
    clear_inputs();
    bus.exception = 1'b1; bus.stall = 1'b1;
    tick();
    checks++; if (bus.in_trap !== 1'b1) begin failures++; $display("[TB] FAIL exc_in_trap: got %b want 1", bus.in_trap); end
    checks++; if (bus.addr !== 32'h8000_0180) begin failures++; $display("[TB] FAIL exc_vector: got %h want %h", bus.addr, 32'h8000_0180); end
    checks++; if (bus.epc !== 32'h40) begin failures++; $display("[TB] FAIL exc_epc: got %h want %h", bus.epc, 32'h40); end
    checks++; if (bus.retired !== 32'd1) begin failures++; $display("[TB] FAIL exc_retired: got %0d want 1", bus.retired); end
    clear_inputs();
    bus.jump = 1'b1; bus.instruction = 32'h0008_0000; bus.exception = 1'b1; bus.eret = 1'b1;
    tick();
    checks++; if (bus.addr !== 32'h8000_0184) begin failures++; $display("[TB] FAIL trap_exit: got %h want %h", bus.addr, 32'h8000_0184); end
    checks++; if (bus.in_trap !== 1'b0) begin failures++; $display("[TB] FAIL trap_exit_flag: got %b want 0", bus.in_trap); end
    clear_inputs();
    bus.eret = 1'b1; bus.stall = 1'b1;
    tick();
    checks++; if (bus.addr !== 32'h40) begin failures++; $display("[TB] FAIL eret_addr: got %h want %h", bus.addr, 32'h40); end
    checks++; if (bus.retired !== 32'd2) begin failures++; $display("[TB] FAIL eret_retired: got %0d want 2", bus.retired); end
    clear_inputs();
    bus.exception = 1'b1;
    tick();
    clear_inputs();
    bus.stall = 1'b1;
    tick();
    checks++; if (bus.addr !== 32'h8000_0180) begin failures++; $display("[TB] FAIL trap_stall_addr: got %h want %h", bus.addr, 32'h8000_0180); end
    checks++; if (bus.in_trap !== 1'b0) begin failures++; $display("[TB] FAIL trap_stall_flag: got %b want 0", bus.in_trap); end
    clear_inputs();
    tick();
    checks++; if (bus.addr !== 32'h8000_0184) begin failures++; $display("[TB] FAIL after_trap_stall: got %h want %h", bus.addr, 32'h8000_0184); end
    checks++; if (bus.retired !== 32'd3) begin failures++; $display("[TB] FAIL after_trap_retired: got %0d want 3", bus.retired); end
  endtask

  task automatic test_reset_in_trap();
    reset_to_run();
    bus.jump_reg = 1'b1; bus.rs_data = 32'h40;
    tick();
    clear_inputs();
    bus.exception = 1'b1;
    tick();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.addr !== 32'h0) begin failures++; $display("[TB] FAIL trap_reset_addr: got %h want %h", bus.addr, 32'h0); end
    checks++; if (bus.epc !== 32'h0) begin failures++; $display("[TB] FAIL trap_reset_epc: got %h want %h", bus.epc, 32'h0); end
    checks++; if (bus.in_trap !== 1'b0) begin failures++; $display("[TB] FAIL trap_reset_flag: got %b want 0", bus.in_trap); end
    checks++; if (bus.retired !== 32'd0) begin failures++; $display("[TB] FAIL trap_reset_retired: got %0d want 0", bus.retired); end
  endtask

  task automatic test_align();
    reset_to_run();
    bus.jump_reg = 1'b1; bus.rs_data = 32'h100;
    tick();
`ifdef PC_ALIGN_CHECK_EN
    bus.rs_data = 32'h1236;
    #1;
    checks++; if (bus.misaligned !== 1'b1) begin failures++; $display("[TB] FAIL misaligned_pulse: got %b want 1", bus.misaligned); end
    tick();
    checks++; if (bus.addr !== 32'h8000_0180) begin failures++; $display("[TB] FAIL misaligned_vector: got %h want %h", bus.addr, 32'h8000_0180); end
    checks++; if (bus.epc !== 32'h100) begin failures++; $display("[TB] FAIL misaligned_epc: got %h want %h", bus.epc, 32'h100); end
    checks++; if (bus.in_trap !== 1'b1) begin failures++; $display("[TB] FAIL misaligned_trap: got %b want 1", bus.in_trap); end
    checks++; if (bus.retired !== 32'd1) begin failures++; $display("[TB] FAIL misaligned_retired: got %0d want 1", bus.retired); end
`else
    bus.rs_data = 32'h1237;
    tick();
    checks++; if (bus.addr !== 32'h1234) begin failures++; $display("[TB] FAIL jr_low_bits: got %h want %h", bus.addr, 32'h1234); end
    checks++; if (bus.in_trap !== 1'b0) begin failures++; $display("[TB] FAIL jr_low_bits_trap: got %b want 0", bus.in_trap); end
`endif
    clear_inputs();
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_branch_jump();
    test_bne();
    test_wrap();
    test_boot_ignore();
    test_stall();
    test_exception();
    test_reset_in_trap();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the single-cycle MIPS core, replacing the fixed 32-bit PC.
- Computes next fetch address: sequential, BEQ/BNE branch, J/JAL jump, JR register jump.
- Adds stall hold, exception vectoring with an EPC register, ERET return, a boot state and a retired-instruction counter.
- Sits between instruction memory address input and the control unit/register file.

Parameters:
ADDR_W, 32, PC/address width; legal range 28..32.
RESET_ADDR, 32'h0000_0000, first fetch address after reset (truncated to ADDR_W).
EXC_VECTOR, 32'h8000_0180, exception handler address (truncated to ADDR_W).
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
instruction  in  32  current instruction; [15:0] branch offset, [25:0] jump index
zero  in  1  ALU zero flag
branch  in  1  conditional branch instruction
branch_ne  in  1  invert condition (BNE)
jump  in  1  J/JAL
jump_reg  in  1  JR; target from rs_data
rs_data  in  ADDR_W  register-jump target
stall  in  1  hold PC this cycle
exception  in  1  trap request for the current instruction
eret  in  1  return from exception
addr  out  ADDR_W  current fetch address (registered)
pc_plus4  out  ADDR_W  addr+4, combinational (JAL link value)
epc  out  ADDR_W  saved exception PC
in_trap  out  1  high during the TRAP state
retired  out  CNT_W  count of advanced instructions

Behaviour:
- Reset, synchronous: addr=RESET_ADDR, epc=0, retired=0, state=BOOT, in_trap=0.
- All control inputs are sampled on the rising edge; addr updates one cycle after sampling.
- States:
  - BOOT: holds addr=RESET_ADDR for exactly one cycle, ignores all control inputs, then goes to RUN.
  - RUN: normal next-PC selection.
  - TRAP: one cycle. addr=EXC_VECTOR. branch, jump, jump_reg and eret are ignored; exception is ignored. Next cycle addr=EXC_VECTOR+4 (or held if stall), state=RUN.
- RUN priority, highest first:
  1. exception: epc<=addr, addr<=EXC_VECTOR, enter TRAP.
  2. eret: addr<=epc.
  3. stall: addr held.
  4. jump_reg: addr<=rs_data with bits [1:0] forced to 0.
  5. jump: addr<={pc_plus4[ADDR_W-1:28], instruction[25:0], 2'b00}.
  6. Branch taken, i.e. branch & (zero ^ branch_ne): addr<=pc_plus4 + (sign_ext(instruction[15:0])<<2).
  7. Otherwise addr<=pc_plus4.
- Arithmetic is modulo 2^ADDR_W; wrap-around at the top of the address space is silent.
- pc_plus4 = addr+4 in every state.
- retired increments when state is RUN, stall=0 and exception=0; it also increments on eret. It wraps at 2^CNT_W.
- Simultaneous exception and stall: exception wins.
- exception while in BOOT is ignored.
- Reset asserted in any state, including mid-TRAP, has full reset effect on the next edge.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - jump_reg with rs_data[1:0]!=0 raises an internal misalignment trap, identical to exception: epc<=addr (the JR's address), addr<=EXC_VECTOR, enter TRAP.
  - Adds output misaligned (1 bit), pulsed high for that cycle.
- Undefined: low bits are silently forced to 0; no misaligned port.

Decomposition:
- Package pc_pkg holds:
  - State enum: BOOT, RUN, TRAP.
  - Localparam constants: BRANCH_SHIFT=2, JUMP_IDX_W=26.
  - Next-PC select encoding.
- One sub-module, pc_next_calc: combinational branch/jump target and pc_plus4 generator, parametrised by ADDR_W.
- The FSM, EPC register and counter stay in pc_unit.

Test Plan:
- Reset held 1 cycle then released -> addr=0x00000000 for BOOT cycle; two RUN edges later addr=0x00000008, retired=2.
- From addr=0x8, branch=1, zero=1, instruction=0x00001000 -> addr=0x0000400C. Then instruction=0x0000FF98 -> addr=0x00003E70.
- branch=1, branch_ne=1, zero=1 at addr=0x10 -> addr=0x14 (not taken). Same with zero=0 -> taken.
- jump=1, instruction=0x00080000 at addr=0x3E70 -> addr=0x00200000. jump_reg=1, rs_data=0x1234 -> addr=0x1234.
- exception at addr=0x40 -> in_trap=1, addr=0x80000180, epc=0x40. Concurrent jump is ignored in TRAP. Next addr=0x80000184. eret -> addr=0x40.
- stall=1 for 3 cycles at addr=0x20 -> addr and retired are frozen. Reset asserted during TRAP -> addr=RESET_ADDR, epc=0, in_trap=0. With PC_ALIGN_CHECK_EN, jump_reg with rs_data=0x1236 -> misaligned=1, addr=EXC_VECTOR.
